async_fifo_read_ctrl: RTL and testbench

Read-side controller for the async FIFO, running entirely in the read clock domain. It owns the read pointer and synchronises the gray-coded write pointer from the write domain. It derives empty and occupancy, and drives r_en/r_adrs into the dual-clock RAM. RAM read data is presented to the consumer through a first-word-fall-through valid/ready output stage, with a 2-entry output buffer that sustains one word per clock.

---
 rtl/async_fifo_read_ctrl.sv | 64 ++++++
 tb/tb_async_fifo_read_ctrl.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_read_ctrl.sv
// async_fifo_read_ctrl: read-domain pointer, write-pointer sync and 2-entry FWFT output stage
module async_fifo_read_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 3,
  localparam int PTR_SIZE = ADDR_WIDTH + 1
) (
  input  logic                  r_clk,
  input  logic                  reset,
  input  logic [PTR_SIZE-1:0]   w_ptr_gray,
  input  logic [DATA_WIDTH-1:0] ram_r_data,
  input  logic                  rd_ready,
  output logic                  r_en,
  output logic [ADDR_WIDTH-1:0] r_adrs,
  output logic [PTR_SIZE-1:0]   r_ptr_gray,
  output logic                  empty,
  output logic [PTR_SIZE-1:0]   level,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data
);
  function automatic logic [PTR_SIZE-1:0] gray2bin(input logic [PTR_SIZE-1:0] g);
    logic [PTR_SIZE-1:0] b;
    for (int i = 0; i < PTR_SIZE; i++) b[i] = ^(g >> i);
    return b;
  endfunction
  logic [PTR_SIZE-1:0]   sync1, sync2, w_bin_sync, r_ptr_bin, r_ptr_next;
  logic [DATA_WIDTH-1:0] buf0, buf1;
  logic [1:0]            held, held_after_pop;
  logic                  in_flight, pop;
  assign w_bin_sync = gray2bin(sync2);
  assign empty = r_ptr_bin == w_bin_sync;
  assign level = w_bin_sync - r_ptr_bin;
  assign r_adrs = r_ptr_bin[ADDR_WIDTH-1:0];
  assign rd_valid = held != 2'd0;
  assign rd_data = buf0;
  assign pop = rd_valid & rd_ready;
  assign held_after_pop = held - {1'b0, pop};
  // words already held or on their way, net of this cycle's pop, must leave a free slot
  assign r_en = !reset && !empty && ({1'b0, held} + {2'b0, in_flight} < 3'd2 + {2'b0, pop});
  assign r_ptr_next = r_ptr_bin + PTR_SIZE'(r_en);
  always_ff @(posedge r_clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      r_ptr_bin <= '0;
      r_ptr_gray <= '0;
      in_flight <= 1'b0;
      held <= 2'd0;
      buf0 <= '0;
      buf1 <= '0;
    end else begin
      sync1 <= w_ptr_gray;
      sync2 <= sync1;
      r_ptr_bin <= r_ptr_next;
      r_ptr_gray <= r_ptr_next ^ (r_ptr_next >> 1);
      in_flight <= r_en;
      held <= held_after_pop + {1'b0, in_flight};
      if (pop && held == 2'd2) buf0 <= buf1;
      if (in_flight) begin
        if (held_after_pop == 2'd0) buf0 <= ram_r_data;
        else buf1 <= ram_r_data;
      end
    end
  end
endmodule

// File: tb/tb_async_fifo_read_ctrl.sv
// tb_async_fifo_read_ctrl: randomized scenarios checked against a queue-based FIFO model
module tb_async_fifo_read_ctrl;
  logic        clk = 1'b0, reset = 1'b1, rd_ready = 1'b0;
  logic [3:0]  w_ptr_gray = 4'd0;
  logic [31:0] ram_r_data = 32'd0;
  logic        r_en, empty, rd_valid;
  logic [2:0]  r_adrs;
  logic [3:0]  r_ptr_gray, level;
  logic [31:0] rd_data;
  logic [31:0] mem [8];
  logic [31:0] exp_q [$];
  int n_tests = 0, n_fail = 0;
  int w_cnt = 0, consumed = 0, fetched = 0, wd1 = 0, wd2 = 0;
  logic [3:0] m_level, m_gray;

  async_fifo_read_ctrl dut (
    .r_clk(clk), .reset(reset), .w_ptr_gray(w_ptr_gray), .ram_r_data(ram_r_data),
    .rd_ready(rd_ready), .r_en(r_en), .r_adrs(r_adrs), .r_ptr_gray(r_ptr_gray),
    .empty(empty), .level(level), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;
  // RAM returns garbage whenever it was not read, so stray captures show up
  always @(posedge clk) ram_r_data <= r_en ? mem[r_adrs] : $urandom;

  function automatic logic [3:0] g(input int b);
    logic [3:0] v;
    v = 4'(b & 15);
    return v ^ (v >> 1);
  endfunction

  task automatic write_word(input logic [31:0] d);
    mem[w_cnt % 8] = d;
    exp_q.push_back(d);
    w_cnt++;
    w_ptr_gray = g(w_cnt);
  endtask

  task automatic tick(output bit popped, output logic [31:0] got, output logic [31:0] want);
    bit en_now, rst_now;
    int w_now;
    #1;
    popped = rd_valid && rd_ready && !reset;
    got = rd_data;
    want = exp_q.size() != 0 ? exp_q[0] : 32'hxxxxxxxx;
    if (popped) begin
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      consumed++;
    end
    en_now = r_en;
    rst_now = reset;
    w_now = w_cnt;
    @(posedge clk);
    @(negedge clk);
    if (rst_now) begin
      fetched = 0; wd1 = 0; wd2 = 0;
    end else begin
      wd2 = wd1; wd1 = w_now;
      if (en_now) fetched++;
    end
    m_level = 4'((wd2 - fetched) & 15);
    m_gray = g(fetched);
    #1;
  endtask

  task automatic test_reset();
    bit p; logic [31:0] got, want;
    for (int i = 0; i < 2; i++) begin
      tick(p, got, want);
      n_tests++;
      if ({r_en, empty, rd_valid, level, r_ptr_gray, rd_data} !== {3'b010, 4'd0, 4'd0, 32'd0}) begin
        n_fail++;
        $display("FAIL reset_state: en/empty/valid=%b%b%b level=%0d gray=%b data=%h, need 010 0 0000 0",
                 r_en, empty, rd_valid, level, r_ptr_gray, rd_data);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_single();
    bit p; logic [31:0] got, want;
    rd_ready = 1'b1;
    write_word(32'hA5A5_0001);
    tick(p, got, want);
    n_tests++;
    if ({empty, r_en} !== 2'b10) begin n_fail++; $display("FAIL single_c1: empty/r_en=%b%b need 10", empty, r_en); end
    tick(p, got, want);
    n_tests++;
    if ({empty, r_en, r_adrs, level} !== {2'b01, 3'd0, 4'd1}) begin
      n_fail++; $display("FAIL single_c2: empty/r_en=%b%b adrs=%0d level=%0d need 01 0 1", empty, r_en, r_adrs, level);
    end
    tick(p, got, want);
    n_tests++;
    if ({rd_valid, r_ptr_gray} !== 5'b0_0001) begin
      n_fail++; $display("FAIL single_c3: valid=%b gray=%b need 0 0001", rd_valid, r_ptr_gray);
    end
    tick(p, got, want);
    n_tests++;
    if ({rd_valid, rd_data} !== {1'b1, 32'hA5A5_0001}) begin
      n_fail++; $display("FAIL single_c4: valid=%b data=%h need 1 a5a50001", rd_valid, rd_data);
    end
    tick(p, got, want);
    n_tests++;
    if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_c5: valid=%b need 0", rd_valid); end
  endtask

  task automatic test_back_pressure();
    bit p; logic [31:0] got, want;
    int pulses = 0, first = -1, last = -1, n = 0;
    rd_ready = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) write_word($urandom);
      #1;
      if (r_en) begin
        pulses++;
        n_tests++;
        if (r_adrs !== 3'(fetched)) begin n_fail++; $display("FAIL bp_adrs: adrs=%0d need %0d", r_adrs, fetched & 7); end
      end
      tick(p, got, want);
    end
    n_tests++;
    if (pulses != 2 || level !== 4'd6 || rd_valid !== 1'b1 || r_en !== 1'b0 || rd_data !== exp_q[0]) begin
      n_fail++;
      $display("FAIL bp_stall: pulses=%0d level=%0d valid=%b r_en=%b data=%h need 2 6 1 0 %h",
               pulses, level, rd_valid, r_en, rd_data, exp_q[0]);
    end
    rd_ready = 1'b1;
    for (int c = 0; c < 30 && n < 8; c++) begin
      tick(p, got, want);
      if (p) begin
        n++;
        if (first < 0) first = c;
        last = c;
        n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL bp_order: word %0d got %h need %h", n - 1, got, want); end
      end
    end
    n_tests++;
    if (n != 8 || last - first != 7 || empty !== 1'b1 || level !== 4'd0) begin
      n_fail++;
      $display("FAIL bp_drain: words=%0d span=%0d empty=%b level=%0d need 8 7 1 0", n, last - first, empty, level);
    end
  endtask

  task automatic test_throughput();
    bit p; logic [31:0] got, want;
    int first = -1, last = -1, n = 0;
    rd_ready = 1'b1;
    for (int c = 0; c < 30 && n < 12; c++) begin
      if (c < 12) write_word($urandom);
      tick(p, got, want);
      if (p) begin
        n++;
        if (first < 0) first = c;
        last = c;
        n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL tp_order: word %0d got %h need %h", n - 1, got, want); end
      end
    end
    n_tests++;
    if (n != 12 || last - first != 11 || exp_q.size() != 0) begin
      n_fail++; $display("FAIL tp_rate: words=%0d span=%0d left=%0d need 12 11 0", n, last - first, exp_q.size());
    end
  endtask

  task automatic test_wrap();
    bit p; logic [31:0] got, want;
    int n = 0;
    reset = 1'b1; w_cnt = 0; w_ptr_gray = 4'd0; consumed = 0; exp_q.delete();
    tick(p, got, want);
    reset = 1'b0;
    for (int c = 0; c < 400 && n < 20; c++) begin
      rd_ready = $urandom_range(0, 3) != 0;
      if (w_cnt < 20 && w_cnt - consumed < 8 && $urandom_range(0, 3) != 0) write_word(32'(w_cnt));
      #1;
      n_tests++;
      if (level !== m_level || empty !== (m_level == 4'd0) || r_ptr_gray !== m_gray || (r_en && empty)) begin
        n_fail++;
        $display("FAIL wrap_ptrs: level=%0d empty=%b gray=%b r_en=%b need level %0d gray %b",
                 level, empty, r_ptr_gray, r_en, m_level, m_gray);
      end
      tick(p, got, want);
      if (p) begin
        n++;
        n_tests++;
        if (got !== want) begin n_fail++; $display("FAIL wrap_order: word %0d got %h need %h", n - 1, got, want); end
      end
    end
    n_tests++;
    if (n != 20 || r_ptr_gray !== 4'b0110 || empty !== 1'b1) begin
      n_fail++; $display("FAIL wrap_end: words=%0d gray=%b empty=%b need 20 0110 1", n, r_ptr_gray, empty);
    end
  endtask

  task automatic test_mid_reset();
    bit p; logic [31:0] got, want;
    int c = 0;
    rd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin write_word($urandom); tick(p, got, want); end
    while (!r_en && c < 10) begin tick(p, got, want); c++; end
    n_tests++;
    if (!r_en) begin n_fail++; $display("FAIL mr_fetch: r_en=%b need 1 within 10 cycles", r_en); end
    tick(p, got, want);
    tick(p, got, want);
    reset = 1'b1; w_cnt = 0; w_ptr_gray = 4'd0; consumed = 0; exp_q.delete();
    tick(p, got, want);
    reset = 1'b0;
    n_tests++;
    if ({rd_valid, empty, r_ptr_gray, level} !== {2'b01, 4'd0, 4'd0}) begin
      n_fail++; $display("FAIL mr_after: valid=%b empty=%b gray=%b level=%0d need 0 1 0000 0", rd_valid, empty, r_ptr_gray, level);
    end
    rd_ready = 1'b1;
    tick(p, got, want);
    tick(p, got, want);
    n_tests++;
    if ({rd_valid, r_en, rd_data} !== {2'b00, 32'd0}) begin
      n_fail++; $display("FAIL mr_discard: valid=%b r_en=%b data=%h need 0 0 0", rd_valid, r_en, rd_data);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_back_pressure();
    test_throughput();
    test_wrap();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
